// File: rtl/adder_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : adder_bist_checker
//  Purpose  : Built-in self-test engine for an N-bit adder. On start it walks
//             every {cin, a, b} combination (cin outermost, b innermost) into
//             the adder under test. It holds each vector for SETTLE cycles and
//             then compares the adder's {cout, sum} with a golden sum. It
//             counts mismatches and captures the first failing vector.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             start               - one-cycle pulse, starts a run from IDLE/DONE
//             dut_a/dut_b/dut_cin - registered stimulus to the adder
//             dut_sum/dut_cout    - adder result, sampled only in SAMPLE
//             busy/done/pass      - run status; pass is valid with done
//             err_count           - saturating mismatch count
//             fail_valid/fail_vec - first failing {cin,a,b}
//  Revision : 1.0 - initial release
// ============================================================================
module adder_bist_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   output logic                 dut_cin,
   input  logic [WIDTH-1:0]     dut_sum,
   input  logic                 dut_cout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          err_count,
   output logic                 fail_valid,
   output logic [2*WIDTH:0]     fail_vec
);

   localparam int         VW          = 2*WIDTH + 1;
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state;
   logic [VW-1:0]   vec;
   logic [3:0]      settle_cnt;
   logic [WIDTH:0]  golden;
   logic            mismatch;

   // The vector register is the stimulus register; the adder inputs are
   // plain slices of it, so they change only on clock edges.
   assign dut_cin = vec[VW-1];
   assign dut_a   = vec[2*WIDTH-1:WIDTH];
   assign dut_b   = vec[WIDTH-1:0];

   // The golden sum is kept at WIDTH+1 bits so the carry-out is part of it.
   always_comb begin
      golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
      mismatch = ({dut_cout, dut_sum} != golden);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  vec        <= '0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_DRIVE;
               end else if (state == S_DONE) begin
                  // Result flags register here, once the final count is stable.
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_count == 16'd0);
               end
            end

            S_DRIVE: begin
               settle_cnt <= SETTLE_LOAD;
               state      <= (SETTLE == 1) ? S_SAMPLE : S_WAIT;
            end

            S_WAIT: begin
               // The counter reaches 0 on this edge when it reads 1 now.
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt == 4'd1) begin
                  state <= S_SAMPLE;
               end
            end

            S_SAMPLE: begin
               if (mismatch) begin
                  if (err_count != 16'hFFFF) begin
                     err_count <= err_count + 16'd1;
                  end
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= vec;
                  end
               end
               // The last vector is held on the adder until the next start.
               if (&vec) begin
                  state <= S_DONE;
               end else begin
                  vec   <= vec + 1'b1;
                  state <= S_DRIVE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_bist_checker
//  Purpose  : Directed bench for adder_bist_checker. One instance uses
//             WIDTH=1/SETTLE=1 with a full adder that can be made faulty. A
//             second instance uses WIDTH=4/SETTLE=3 with a correct adder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_bist_checker;

   logic clk;
   logic rst_n;

   // WIDTH=1, SETTLE=1 instance
   logic        start1;
   logic        a1, b1, cin1, sum1, cout1;
   logic        busy1, done1, pass1, fail_valid1;
   logic [15:0] err1;
   logic [2:0]  fail_vec1;
   int          fault_mode;   // 0 correct, 1 cout stuck-at-0, 2 sum inverted

   // WIDTH=4, SETTLE=3 instance
   logic        start4;
   logic [3:0]  a4, b4, sum4;
   logic        cin4, cout4;
   logic        busy4, done4, pass4, fail_valid4;
   logic [15:0] err4;
   logic [8:0]  fail_vec4;

   int n_vec;
   int n_err;

   adder_bist_checker #(.WIDTH(1), .SETTLE(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
      .dut_sum(sum1), .dut_cout(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fail_valid1), .fail_vec(fail_vec1)
   );

   adder_bist_checker #(.WIDTH(4), .SETTLE(3)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .dut_a(a4), .dut_b(b4), .dut_cin(cin4),
      .dut_sum(sum4), .dut_cout(cout4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .fail_valid(fail_valid4), .fail_vec(fail_vec4)
   );

   // Adders under test
   always_comb begin
      logic [1:0] s;
      s     = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      sum1  = (fault_mode == 2) ? ~s[0] : s[0];
      cout1 = (fault_mode == 1) ? 1'b0 : s[1];
   end
   assign {cout4, sum4} = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit w4, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if ((w4 ? done4 : done1) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; fault_mode = 0;
      tick(2);
      n_vec++;
      if ({busy1, done1, pass1, fail_valid1, err1, fail_vec1, a1, b1, cin1} !== '0) begin
         n_err++;
         $display("FAIL reset_w1: got busy=%b done=%b pass=%b fv=%b err=%0d vec=%b a=%b b=%b cin=%b, want all 0",
                  busy1, done1, pass1, fail_valid1, err1, fail_vec1, a1, b1, cin1);
      end
      n_vec++;
      if ({busy4, done4, pass4, fail_valid4, err4, fail_vec4, a4, b4, cin4} !== '0) begin
         n_err++;
         $display("FAIL reset_w4: got busy=%b done=%b pass=%b fv=%b err=%0d vec=%h, want all 0",
                  busy4, done4, pass4, fail_valid4, err4, fail_vec4);
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   // Correct full adder: sequence, timing and result flags.
   task automatic test_w1_clean;
      fault_mode = 0;
      start1 = 1'b1; tick(1); start1 = 1'b0;       // edge 0
      tick(1);                                      // edge 1
      for (int k = 0; k < 8; k++) begin
         n_vec++;
         if ({cin1, a1, b1} !== 3'(k)) begin
            n_err++;
            $display("FAIL seq_w1[%0d]: got {cin,a,b}=%b, want %b", k, {cin1, a1, b1}, 3'(k));
         end
         if (k < 7) tick(2);
      end
      tick(1);                                      // edge 16
      n_vec++;
      if (done1 !== 1'b0) begin
         n_err++;
         $display("FAIL done_early_w1: got done=%b after 16 edges, want 0", done1);
      end
      tick(1);                                      // edge 17
      n_vec++;
      if ({done1, busy1, pass1, fail_valid1, err1} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'd0}) begin
         n_err++;
         $display("FAIL result_w1_clean: got done=%b busy=%b pass=%b fv=%b err=%0d, want 1 0 1 0 0",
                  done1, busy1, pass1, fail_valid1, err1);
      end
      n_vec++;
      if ({cin1, a1, b1} !== 3'b111) begin
         n_err++;
         $display("FAIL hold_last_w1: got {cin,a,b}=%b, want 111", {cin1, a1, b1});
      end
   endtask

   task automatic run_w1(input int mode, output bit ok);
      fault_mode = mode;
      start1 = 1'b1; tick(1); start1 = 1'b0;
      wait_done(1'b0, 100, ok);
   endtask

   task automatic test_w1_cout_stuck;
      bit ok;
      run_w1(1, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL timeout_cout_stuck: got done=%b, want 1", done1);
      end
      n_vec++;
      if ({err1, fail_vec1, fail_valid1, pass1} !== {16'd4, 3'b011, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL cout_stuck: got err=%0d fvec=%b fv=%b pass=%b, want 4 011 1 0",
                  err1, fail_vec1, fail_valid1, pass1);
      end
   endtask

   task automatic test_w1_sum_inverted;
      bit ok;
      run_w1(2, ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL timeout_sum_inv: got done=%b, want 1", done1);
      end
      n_vec++;
      if ({err1, fail_vec1, fail_valid1, pass1} !== {16'd8, 3'b000, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL sum_inv: got err=%0d fvec=%b fv=%b pass=%b, want 8 000 1 0",
                  err1, fail_vec1, fail_valid1, pass1);
      end
   endtask

   // Restart from DONE with a result pending, now against a correct adder.
   task automatic test_restart_from_done;
      bit ok;
      run_w1(1, ok);
      n_vec++;
      if (!ok || err1 !== 16'd4) begin
         n_err++;
         $display("FAIL restart_setup: got done=%b err=%0d, want 1 4", done1, err1);
      end
      fault_mode = 0;
      start1 = 1'b1; tick(1); start1 = 1'b0;
      n_vec++;
      if ({done1, busy1, err1, fail_valid1} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL restart_clear: got done=%b busy=%b err=%0d fv=%b, want 0 1 0 0",
                  done1, busy1, err1, fail_valid1);
      end
      wait_done(1'b0, 100, ok);
      n_vec++;
      if (!ok || {pass1, err1} !== {1'b1, 16'd0}) begin
         n_err++;
         $display("FAIL restart_result: got done=%b pass=%b err=%0d, want 1 1 0", done1, pass1, err1);
      end
   endtask

   // WIDTH=4, SETTLE=3: timing, ignored start mid-run, result.
   task automatic test_back_to_back_start;
      start4 = 1'b1; tick(1); start4 = 1'b0;       // edge 0
      tick(400);                                    // edge 400: vector 100
      n_vec++;
      if ({cin4, a4, b4} !== 9'd100) begin
         n_err++;
         $display("FAIL vec100_w4: got %0d, want 100", {cin4, a4, b4});
      end
      start4 = 1'b1; tick(1); start4 = 1'b0;       // edge 401
      n_vec++;
      if ({busy4, cin4, a4, b4} !== {1'b1, 9'd100}) begin
         n_err++;
         $display("FAIL start_ignored_w4: got busy=%b vec=%0d, want 1 100", busy4, {cin4, a4, b4});
      end
      tick(1647);                                   // edge 2048
      n_vec++;
      if (done4 !== 1'b0) begin
         n_err++;
         $display("FAIL done_early_w4: got done=%b after 2048 edges, want 0", done4);
      end
      tick(1);                                      // edge 2049
      n_vec++;
      if ({done4, busy4, pass4, err4, fail_valid4} !== {1'b1, 1'b0, 1'b1, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL result_w4: got done=%b busy=%b pass=%b err=%0d fv=%b, want 1 0 1 0 0",
                  done4, busy4, pass4, err4, fail_valid4);
      end
   endtask

   task automatic test_reset_midrun;
      bit ok;
      start4 = 1'b1; tick(1); start4 = 1'b0;
      tick(800);                                    // vector 200
      n_vec++;
      if ({cin4, a4, b4} !== 9'd200) begin
         n_err++;
         $display("FAIL vec200_w4: got %0d, want 200", {cin4, a4, b4});
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy4, done4, pass4, fail_valid4, err4, fail_vec4, a4, b4, cin4} !== '0) begin
         n_err++;
         $display("FAIL async_reset_w4: got busy=%b done=%b err=%0d vec=%0d, want all 0",
                  busy4, done4, err4, {cin4, a4, b4});
      end
      tick(2);
      rst_n = 1'b1;
      tick(1);
      start4 = 1'b1; tick(1); start4 = 1'b0;
      wait_done(1'b1, 2100, ok);
      n_vec++;
      if (!ok || {pass4, err4, fail_valid4} !== {1'b1, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL post_reset_run_w4: got done=%b pass=%b err=%0d fv=%b, want 1 1 0 0",
                  done4, pass4, err4, fail_valid4);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_w1_clean();
      test_w1_cout_stuck();
      test_w1_sum_inverted();
      test_restart_from_done();
      test_back_to_back_start();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_bist_checker.md
Name: adder_bist_checker

Overview:
Synthesizable built-in self-test engine for the team's adder datapath. On `start` it drives every {cin, a, b} combination into an N-bit adder DUT, in the same exhaustive order the adder benches use: cin outermost, then a, then b innermost. After each vector it samples the DUT sum/carry, compares them against an internal golden sum, and counts mismatches. Sits beside the adder under test and replaces the simulation-only stimulus/monitor flow with an on-chip pass/fail result.

Parameters:
- WIDTH, 4, operand width of the DUT adder (legal range 1..8).
- SETTLE, 1, cycles the vector is held before sampling (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
- dut_a  output  WIDTH  operand A to DUT.
- dut_b  output  WIDTH  operand B to DUT.
- dut_cin  output  1  carry-in to DUT.
- dut_sum  input  WIDTH  DUT sum.
- dut_cout  input  1  DUT carry-out.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start.
- pass  output  1  valid with done; 1 when err_count==0.
- err_count  output  16  mismatch count; saturates at 16'hFFFF.
- fail_valid  output  1  at least one mismatch has been captured.
- fail_vec  output  2*WIDTH+1  {cin,a,b} of the first failing vector.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, vector index=0, dut_a/dut_b/dut_cin=0, busy/done/pass/fail_valid=0, err_count=0, fail_vec=0.
- Vector index v is 2*WIDTH+1 bits wide. dut_cin=v[MSB], dut_a=v[2W-1:W], dut_b=v[W-1:0]. All three are driven from registers. Total vectors = 2^(2W+1).
- Golden result: {exp_cout, exp_sum} = dut_a + dut_b + dut_cin, computed at WIDTH+1 bits with no truncation. A mismatch is {dut_cout,dut_sum} != {exp_cout,exp_sum}.
- FSM states:
  - IDLE: outputs hold. On start: v=0; clear err_count, fail_valid, fail_vec, done, pass; busy=1; go to DRIVE.
  - DRIVE: the vector is on the DUT inputs. Load settle counter=SETTLE-1. If SETTLE==1 go directly to SAMPLE; otherwise go to WAIT.
  - WAIT: decrement the counter each cycle; go to SAMPLE when it reaches 0.
  - SAMPLE: compare.
    - On mismatch: err_count+1 (saturating). If fail_valid==0, set fail_vec=v and fail_valid=1.
    - If v is the last vector (all ones), go to DONE. Otherwise v=v+1 and go to DRIVE.
  - DONE: busy=0, done=1, pass=(final err_count==0); done and pass register on DONE entry. Outputs hold. On start, behave exactly as start in IDLE.
- Timing: cycles per vector = SETTLE+1. With start sampled at edge 0, done is high after edge 2^(2W+1)*(SETTLE+1)+1.
- start while busy=1 is ignored; the run is not restarted.
- After the last vector, v and the DUT inputs hold the final vector; v does not wrap to 0 until the next start.
- When a mismatch and err_count==FFFF occur in the same SAMPLE, err_count stays FFFF and pass=0.
- rst_n asserted mid-run aborts immediately to reset values. No partial result is retained.
- Inputs dut_sum and dut_cout are sampled only in SAMPLE; their values in other states are don't-care.

Test Plan:
- WIDTH=1, SETTLE=1, correct full adder: one start pulse -> 8 vectors, done after 17 edges, pass=1, err_count=0, fail_valid=0; vector sequence {cin,a,b} = 000,001,010,011,100,101,110,111.
- WIDTH=1, DUT cout stuck-at-0 -> err_count=4 (vectors 011,101,110,111), fail_vec=3'b011, fail_valid=1, pass=0.
- WIDTH=1, DUT sum inverted -> err_count=8, fail_vec=3'b000, pass=0.
- WIDTH=4, SETTLE=3, correct adder -> 512 vectors, done after 2049 edges, pass=1; a start pulse at vector 100 has no effect on the result.
- WIDTH=4: assert rst_n low at vector 200 -> all outputs 0 the same cycle. Release and start -> full clean run, pass=1, err_count=0.
- From DONE with err_count=4 (faulty DUT), swap in a correct DUT and pulse start -> done drops, busy=1, err_count cleared to 0 on the start edge; final pass=1.
